cordic_vec: RTL and testbench

Iterative 16-stage CORDIC in vectoring mode: accepts a first-quadrant vector (x, y) and returns its angle atan2(y, x) and gain-corrected magnitude. It is the inverse of the team's rotation-mode sin/cos unit. It uses the same angle scale, the same gamma_mem arctangent table and the same in_valid/ready/out_valid handshake, so a rotation-mode result can be fed straight back for round-trip checks.

---
 rtl/cordic_vec_if.sv | 24 ++
 rtl/cordic_vec.sv | 182 ++++++++++++++++++
 tb/tb_cordic_vec.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vec_if.sv
// Request/response bundle for cordic_vec: first-quadrant vector in, angle and magnitude out.
interface cordic_vec_if;
   localparam int unsigned IN_W  = 16;
   localparam int unsigned ANG_W = 16;
   localparam int unsigned MAG_W = 18;

   logic [IN_W-1:0]  x;
   logic [IN_W-1:0]  y;
   logic             in_valid;
   logic             ready;
   logic             out_valid;
   logic [ANG_W-1:0] angle;
   logic [MAG_W-1:0] mag;

   modport master (
      output x, y, in_valid,
      input  ready, out_valid, angle, mag
   );

   modport slave (
      input  x, y, in_valid,
      output ready, out_valid, angle, mag
   );
endinterface

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: first-quadrant (x, y) -> atan2(y, x) and magnitude.
// Define CORDIC_VEC_GAIN_COMP_EN to scale mag by 1/K; otherwise mag is the raw K-scaled xr.
module cordic_vec #(
   parameter int unsigned MAX_ITER = 16
) (
   input  logic        clk,
   input  logic        rstb,
   cordic_vec_if.slave bus
);
   localparam int unsigned IN_W  = 16;
   localparam int unsigned XR_W  = 19;
   localparam int unsigned YR_W  = 18;
   localparam int unsigned ZR_W  = 18;
   localparam int unsigned ANG_W = 16;
   localparam int unsigned MAG_W = 18;
   localparam int unsigned IT_W  = 4;
   localparam logic [IT_W-1:0] LAST_ITER = IT_W'(MAX_ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic signed [XR_W-1:0]  xr_q, xr_d;
   logic signed [YR_W-1:0]  yr_q, yr_d;
   logic signed [ZR_W-1:0]  zr_q, zr_d;
   logic [IT_W-1:0]         iter_q, iter_d;
   logic                    zero_q, zero_d;
   logic                    ready_q, ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [ANG_W-1:0]        angle_q, angle_d;
   logic [MAG_W-1:0]        mag_q, mag_d;

   logic [ANG_W-1:0]        gamma_mem;
   logic signed [ZR_W-1:0]  gamma_s;
   logic signed [YR_W-1:0]  y_shift;
   logic signed [XR_W-1:0]  x_shift;
   logic                    y_nonneg;
   logic [ANG_W-1:0]        angle_c;
   logic [MAG_W-1:0]        mag_c;

   // atan(2^-i) with pi/2 == 2^16
   always_comb begin
      gamma_mem = '0;
      case (iter_q)
         4'd0:  gamma_mem = 16'd32768;
         4'd1:  gamma_mem = 16'd19344;
         4'd2:  gamma_mem = 16'd10221;
         4'd3:  gamma_mem = 16'd5188;
         4'd4:  gamma_mem = 16'd2604;
         4'd5:  gamma_mem = 16'd1303;
         4'd6:  gamma_mem = 16'd652;
         4'd7:  gamma_mem = 16'd326;
         4'd8:  gamma_mem = 16'd163;
         4'd9:  gamma_mem = 16'd81;
         4'd10: gamma_mem = 16'd41;
         4'd11: gamma_mem = 16'd20;
         4'd12: gamma_mem = 16'd10;
         4'd13: gamma_mem = 16'd5;
         4'd14: gamma_mem = 16'd3;
         4'd15: gamma_mem = 16'd1;
      endcase
   end

   assign gamma_s  = ZR_W'(gamma_mem);
   assign y_shift  = yr_q >>> iter_q;
   assign x_shift  = xr_q >>> iter_q;
   assign y_nonneg = ~yr_q[YR_W-1];

   // Accumulated angle saturates into the 16-bit output range
   always_comb begin
      if (zr_q[ZR_W-1]) begin
         angle_c = '0;
      end else if (zr_q[ANG_W]) begin
         angle_c = '1;
      end else begin
         angle_c = zr_q[ANG_W-1:0];
      end
   end

`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam int unsigned     PROD_W   = MAG_W + 16;
   localparam logic [15:0]     GAIN_INV = 16'd39797;
   assign mag_c = MAG_W'((PROD_W'(xr_q[MAG_W-1:0]) * PROD_W'(GAIN_INV)) >> 16);
`else
   assign mag_c = xr_q[MAG_W-1:0];
`endif

   // Next-state and next-register values
   always_comb begin
      state_d     = state_q;
      xr_d        = xr_q;
      yr_d        = yr_q;
      zr_d        = zr_q;
      iter_d      = iter_q;
      zero_d      = zero_q;
      ready_d     = ready_q;
      out_valid_d = out_valid_q;
      angle_d     = angle_q;
      mag_d       = mag_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && ready_q) begin
               xr_d        = XR_W'(bus.x);
               yr_d        = YR_W'(bus.y);
               zr_d        = '0;
               iter_d      = '0;
               zero_d      = (bus.x == IN_W'(0)) && (bus.y == IN_W'(0));
               ready_d     = 1'b0;
               out_valid_d = 1'b0;
               state_d     = ITER;
            end
         end

         ITER: begin
            if (y_nonneg) begin
               xr_d = xr_q + XR_W'(y_shift);
               yr_d = YR_W'(XR_W'(yr_q) - x_shift);
               zr_d = zr_q + gamma_s;
            end else begin
               xr_d = xr_q - XR_W'(y_shift);
               yr_d = YR_W'(XR_W'(yr_q) + x_shift);
               zr_d = zr_q - gamma_s;
            end
            iter_d = iter_q + IT_W'(1);
            if (iter_q == LAST_ITER) begin
               state_d = DONE;
            end
         end

         DONE: begin
            angle_d     = zero_q ? '0 : angle_c;
            mag_d       = zero_q ? '0 : mag_c;
            out_valid_d = 1'b1;
            ready_d     = 1'b1;
            state_d     = IDLE;
         end

         default: begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            out_valid_d = 1'b0;
            angle_d     = '0;
            mag_d       = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         xr_q        <= '0;
         yr_q        <= '0;
         zr_q        <= '0;
         iter_q      <= '0;
         zero_q      <= 1'b0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         angle_q     <= '0;
         mag_q       <= '0;
      end else begin
         state_q     <= state_d;
         xr_q        <= xr_d;
         yr_q        <= yr_d;
         zr_q        <= zr_d;
         iter_q      <= iter_d;
         zero_q      <= zero_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         angle_q     <= angle_d;
         mag_q       <= mag_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.angle     = angle_q;
   assign bus.mag       = mag_q;
endmodule

// File: tb/tb_cordic_vec.sv
// Bench for cordic_vec: directed vectors, random round trips, reset and handshake timing.
module tb_cordic_vec;
   localparam int unsigned MAX_ITER = 16;
   localparam real PI      = 3.14159265358979323846;
   localparam int  LAT     = 17;
   localparam int  ANG_TOL = 5;
`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam int  MAG_TOL = 10;
`else
   localparam int  MAG_TOL = 16;
`endif

   logic clk = 1'b0;
   logic rstb;
   int   n_assert = 0;
   int   n_fail   = 0;

   cordic_vec_if bus ();

   cordic_vec #(.MAX_ITER(MAX_ITER)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic real cordic_gain();
      real k;
      k = 1.0;
      for (int i = 0; i < int'(MAX_ITER); i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
      return k;
   endfunction

   function automatic int ref_angle(input int vx, input int vy);
      real a;
      a = $atan2(real'(vy), real'(vx)) * 65536.0 / (PI / 2.0);
      if (a > 65535.0) a = 65535.0;
      return $rtoi(a + 0.5);
   endfunction

   function automatic int ref_mag(input int vx, input int vy);
      real m;
      m = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
`ifndef CORDIC_VEC_GAIN_COMP_EN
      m = m * cordic_gain();
`endif
      return $rtoi(m + 0.5);
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
      int diff;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      n_assert++;
      assert ((diff <= tol) === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   // One transaction; returns edges from accept to out_valid (bounded)
   task automatic run_vec(input int vx, input int vy, output int lat);
      @(negedge clk);
      chk_eq("ready_before_accept", 32'(bus.ready), 32'd1);
      bus.x        = 16'(vx);
      bus.y        = 16'(vy);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic chk_result(input string tag, input int vx, input int vy);
      chk_near($sformatf("%s_angle", tag), int'(bus.angle), ref_angle(vx, vy), ANG_TOL);
      chk_near($sformatf("%s_mag", tag), int'(bus.mag), ref_mag(vx, vy), MAG_TOL);
   endtask

   initial begin
      int lat, a1, m1, w, ang_in, rad, vx, vy;
      int acc_q[$];
      int dx[4];
      int dy[4];

      dx = '{65535, 32768, 28378, 0};
      dy = '{0, 32768, 16384, 16384};

      rstb         = 1'b0;
      bus.in_valid = 1'b0;
      bus.x        = '0;
      bus.y        = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_ready", 32'(bus.ready), 32'd1);
      chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk_eq("rst_angle", 32'(bus.angle), 32'd0);
      chk_eq("rst_mag", 32'(bus.mag), 32'd0);
      @(negedge clk);
      rstb = 1'b1;

      // Directed vectors: axis, diagonal, 30 degrees, y-axis (clamp)
      for (int i = 0; i < 4; i++) begin
         run_vec(dx[i], dy[i], lat);
         chk_eq($sformatf("dir%0d_latency", i), 32'(lat), 32'(LAT));
         chk_result($sformatf("dir%0d", i), dx[i], dy[i]);
      end
      chk_eq("yaxis_clamp", 32'(bus.angle >= 16'hFFFC), 32'd1);

      run_vec(0, 0, lat);
      chk_eq("zero_latency", 32'(lat), 32'(LAT));
      chk_eq("zero_angle", 32'(bus.angle), 32'd0);
      chk_eq("zero_mag", 32'(bus.mag), 32'd0);

      // Round trip: vector built from a random angle must return that angle
      for (int t = 0; t < 16; t++) begin
         ang_in = int'($urandom_range(65471, 64));
         rad    = int'($urandom_range(60000, 30000));
         vx     = $rtoi(real'(rad) * $cos(real'(ang_in) * PI / 131072.0) + 0.5);
         vy     = $rtoi(real'(rad) * $sin(real'(ang_in) * PI / 131072.0) + 0.5);
         run_vec(vx, vy, lat);
         chk_eq($sformatf("rt%0d_latency", t), 32'(lat), 32'(LAT));
         chk_near($sformatf("rt%0d_angle", t), int'(bus.angle), ang_in, ANG_TOL);
         chk_near($sformatf("rt%0d_mag", t), int'(bus.mag), ref_mag(vx, vy), MAG_TOL);
      end

      // Reset during iterations discards the in-flight vector
      @(negedge clk);
      bus.x        = 16'd20000;
      bus.y        = 16'd15000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rstb = 1'b0;
      #1;
      chk_eq("midrst_ready", 32'(bus.ready), 32'd1);
      chk_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk_eq("midrst_angle", 32'(bus.angle), 32'd0);
      chk_eq("midrst_mag", 32'(bus.mag), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      run_vec(20000, 15000, lat);
      chk_eq("postrst_latency", 32'(lat), 32'(LAT));
      chk_result("postrst", 20000, 15000);

      // in_valid held high: accepts only every MAX_ITER+2 edges, inputs frozen per accept
      @(negedge clk);
      bus.x        = 16'd30000;
      bus.y        = 16'd10000;
      bus.in_valid = 1'b1;
      a1 = 0;
      m1 = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.ready) acc_q.push_back(c);
         if (c == 5) begin
            bus.x = 16'd5000;
            bus.y = 16'd40000;
         end
         if (c == 20) begin
            bus.x = 16'd40000;
            bus.y = 16'd5000;
         end
         if (c == 18) begin
            chk_eq("hold_first_valid", 32'(bus.out_valid), 32'd1);
            chk_result("hold_first", 30000, 10000);
            a1 = int'(bus.angle);
            m1 = int'(bus.mag);
         end
         if (c == 35) begin
            chk_eq("hold_busy_valid", 32'(bus.out_valid), 32'd0);
            chk_eq("hold_busy_angle", 32'(bus.angle), 32'(a1));
            chk_eq("hold_busy_mag", 32'(bus.mag), 32'(m1));
         end
         if (c == 36) begin
            chk_eq("hold_second_valid", 32'(bus.out_valid), 32'd1);
            chk_result("hold_second", 5000, 40000);
         end
         @(posedge clk);
         #1;
         if (c == 18) begin
            chk_eq("accept_clears_valid", 32'(bus.out_valid), 32'd0);
            chk_eq("accept_keeps_angle", 32'(bus.angle), 32'(a1));
            chk_eq("accept_keeps_mag", 32'(bus.mag), 32'(m1));
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk_eq("accept_count", 32'(acc_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("accept_edge%0d", i),
                (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(i * 18));
      end
      w = 0;
      while (!bus.out_valid && w < 40) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk_eq("third_latency", 32'(w), 32'd14);
      chk_result("hold_third", 40000, 5000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
